// File: rtl/mac_result_drain_pkg.sv
// Shared definitions for the MAC result drain stage.
// Result width and index width helpers are also used by the MAC array.
package mac_result_drain_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    function automatic int m_width(input int n, input int width);
        return 2 * width + n - 1;
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mac_result_drain_if.sv
// Element stream from the result drain towards the writer/packer.
// The drain is the master; the consumer owns out_ready.
interface mac_result_drain_if #(
    parameter int M_WIDTH = 36,
    parameter int IDX_W   = 3
) ();

    logic [M_WIDTH-1:0] out_data;
    logic [IDX_W-1:0]   out_idx;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output out_data,
        output out_idx,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_last,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/mac_result_bank.sv
// Two-bank ping-pong storage for result vectors.
// Whole-vector write into one bank, single-element read from (bank, idx).
module mac_result_bank #(
    parameter int N       = 5,
    parameter int M_WIDTH = 36,
    parameter int IDX_W   = 3
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic                 wsel,
    input  logic [N*M_WIDTH-1:0] wdata,
    input  logic                 rsel,
    input  logic [IDX_W-1:0]     ridx,
    output logic [M_WIDTH-1:0]   rdata
);

    logic [M_WIDTH-1:0] mem [2][N];

    // Contents need no reset: the reader never exposes an unwritten bank.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < N; i++) begin
                mem[wsel][i] <= wdata[i*M_WIDTH +: M_WIDTH];
            end
        end
    end

    assign rdata = mem[rsel][ridx];

endmodule

// File: rtl/mac_result_drain.sv
// Captures full result vectors from the MAC array into a ping-pong
// buffer and streams them out one element per cycle.
module mac_result_drain
    import mac_result_drain_pkg::*;
#(
    parameter int N       = 5,
    parameter int WIDTH   = 16,
    parameter int M_WIDTH = m_width(N, WIDTH),
    parameter int IDX_W   = idx_w(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         valid_in,
    input  logic [N*M_WIDTH-1:0] C_in,
    mac_result_drain_if.master   res,
    output logic                 overflow,
    output logic                 err_partial,
    output logic                 busy
);

    state_t             state;
    state_t             state_n;
    logic [1:0]         full;
    logic [1:0]         full_n;
    logic               wr_sel;
    logic               wr_sel_n;
    logic               rd_sel;
    logic               rd_sel_n;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_n;
    logic [M_WIDTH-1:0] rd_data;

    logic capture;
    logic partial;
    logic store;
    logic drop;
    logic transfer;
    logic at_last;
    logic retire;

    assign capture  = &valid_in;
    assign partial  = (|valid_in) & ~capture;
    // Capture decides on the bank flags as registered, never on a
    // bank freeing in the same cycle.
    assign store    = capture & ~full[wr_sel];
    assign drop     = capture & full[wr_sel];
    assign transfer = (state == DRAIN) & res.out_ready;
    assign at_last  = (idx == IDX_W'(N - 1));
    assign retire   = transfer & at_last;

    always_comb begin
        full_n   = full;
        rd_sel_n = rd_sel;
        wr_sel_n = wr_sel;
        idx_n    = idx;
        if (retire) begin
            full_n[rd_sel] = 1'b0;
            rd_sel_n       = ~rd_sel;
            idx_n          = '0;
        end else if (transfer) begin
            idx_n = idx + 1'b1;
        end
        if (store) begin
            full_n[wr_sel] = 1'b1;
            wr_sel_n       = ~wr_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Looking at next-cycle flags gives one-cycle capture latency and
    // back-to-back vectors without a bubble.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (full_n[rd_sel]) state_n = DRAIN;
            end
            DRAIN: begin
                if (retire) state_n = full_n[~rd_sel] ? DRAIN : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        res.out_valid = (state == DRAIN);
        res.out_last  = (state == DRAIN) & at_last;
        res.out_idx   = idx;
        res.out_data  = rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full        <= '0;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            idx         <= '0;
            overflow    <= 1'b0;
            err_partial <= 1'b0;
        end else begin
            full   <= full_n;
            wr_sel <= wr_sel_n;
            rd_sel <= rd_sel_n;
            idx    <= idx_n;
            if (drop)    overflow    <= 1'b1;
            if (partial) err_partial <= 1'b1;
        end
    end

    assign busy = |full;

    mac_result_bank #(
        .N       (N),
        .M_WIDTH (M_WIDTH),
        .IDX_W   (IDX_W)
    ) u_bank (
        .clk   (clk),
        .we    (store),
        .wsel  (wr_sel),
        .wdata (C_in),
        .rsel  (rd_sel),
        .ridx  (idx),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_mac_result_drain.sv
// Bench for mac_result_drain: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mac_result_drain;
    import mac_result_drain_pkg::*;

    localparam int N     = 5;
    localparam int WIDTH = 16;
    localparam int MW    = m_width(N, WIDTH);
    localparam int IW    = idx_w(N);

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      valid_in;
    logic [N*MW-1:0]   C_in;
    logic              overflow;
    logic              err_partial;
    logic              busy;

    mac_result_drain_if #(.M_WIDTH(MW), .IDX_W(IW)) rif ();

    mac_result_drain #(.N(N), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .C_in        (C_in),
        .res         (rif),
        .overflow    (overflow),
        .err_partial (err_partial),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: list of stored vectors plus read position in the head.
    logic [N*MW-1:0] q[$];
    int              pos;
    logic            m_ovf;
    logic            m_perr;
    logic            was_full;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            pos    = 0;
            m_ovf  = 1'b0;
            m_perr = 1'b0;
        end else begin
            was_full = (q.size() == 2);
            if (q.size() > 0 && rif.out_ready) begin
                if (pos == N - 1) begin
                    void'(q.pop_front());
                    pos = 0;
                end else begin
                    pos++;
                end
            end
            if (&valid_in) begin
                if (was_full) m_ovf = 1'b1;
                else q.push_back(C_in);
            end else if (valid_in != '0) begin
                m_perr = 1'b1;
            end
        end
    end

    int log_q[$];

    always @(negedge clk) begin
        chk("out_valid", rif.out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_data", rif.out_data, q[0][pos*MW +: MW]);
            chk("out_idx", rif.out_idx, pos);
            chk("out_last", rif.out_last, pos == N - 1);
        end
        chk("busy", busy, q.size() > 0);
        chk("overflow", overflow, m_ovf);
        chk("err_partial", err_partial, m_perr);
        if (rif.out_valid && rif.out_ready) log_q.push_back(int'(rif.out_data));
    end

    function automatic logic [N*MW-1:0] lanes(input int base);
        logic [N*MW-1:0] v;
        for (int i = 0; i < N; i++) v[i*MW +: MW] = MW'(base + i);
        return v;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cap(input int base);
        valid_in = '1;
        C_in     = lanes(base);
        step();
        valid_in = '0;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        valid_in       = '0;
        rif.out_ready  = 1'b0;
        step(2);
        rst = 1'b0;
        log_q.delete();
    endtask

    task automatic expect_log(input string nm, input int b0, input int b1);
        int exp[$];
        for (int i = 0; i < N; i++) exp.push_back(b0 + i);
        if (b1 >= 0) for (int i = 0; i < N; i++) exp.push_back(b1 + i);
        chk({nm, "_count"}, log_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < log_q.size()) chk(nm, log_q[i], exp[i]);
        end
        log_q.delete();
    endtask

    initial begin
        rst           = 1'b1;
        valid_in      = '0;
        C_in          = '0;
        rif.out_ready = 1'b0;

        // reset state
        do_reset();
        chk("rst_valid", rif.out_valid, 0);
        chk("rst_idx", rif.out_idx, 0);
        chk("rst_last", rif.out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_perr", err_partial, 0);

        // single vector
        rif.out_ready = 1'b1;
        cap(1);
        chk("t1_latency", rif.out_valid, 1);
        chk("t1_first", rif.out_data, 1);
        step(6);
        expect_log("t1_data", 1, -1);
        chk("t1_busy", busy, 0);

        // backpressure 1,0,0
        do_reset();
        cap(41);
        for (int c = 0; c < 20; c++) begin
            rif.out_ready = (c % 3 == 0);
            step();
        end
        expect_log("t2_data", 41, -1);

        // two-bank fill and overflow
        do_reset();
        cap(10);
        cap(20);
        cap(30);
        chk("t3_ovf", overflow, 1);
        rif.out_ready = 1'b1;
        step(12);
        expect_log("t3_data", 10, 20);

        // partial valid
        do_reset();
        valid_in = 5'b00101;
        C_in     = lanes(7);
        step();
        valid_in = '0;
        step();
        chk("t4_perr", err_partial, 1);
        chk("t4_valid", rif.out_valid, 0);
        chk("t4_busy", busy, 0);

        // capture on final read, both banks full
        do_reset();
        cap(50);
        cap(60);
        rif.out_ready = 1'b1;
        step(4);
        chk("t5_idx4", rif.out_idx, 4);
        cap(70);
        chk("t5_ovf", overflow, 1);
        step(8);
        expect_log("t5_data", 50, 60);

        // capture on final read, other bank empty
        do_reset();
        rif.out_ready = 1'b1;
        cap(80);
        step(4);
        cap(90);
        chk("t5b_valid", rif.out_valid, 1);
        chk("t5b_idx", rif.out_idx, 0);
        chk("t5b_data", rif.out_data, 90);
        chk("t5b_ovf", overflow, 0);
        step(6);
        expect_log("t5b_data", 80, 90);

        // reset mid-drain
        do_reset();
        rif.out_ready = 1'b1;
        valid_in = 5'b00011;
        step();
        valid_in = '0;
        cap(100);
        step(2);
        chk("t6_idx2", rif.out_idx, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_valid", rif.out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_perr", err_partial, 0);
        step(3);
        chk("t6_quiet", rif.out_valid, 0);
        log_q.delete();
        cap(110);
        chk("t6_idx0", rif.out_idx, 0);
        chk("t6_data", rif.out_data, 110);
        step(6);
        expect_log("t6_data", 110, -1);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int r;
            int rdy_pct;
            r       = $urandom_range(0, 99);
            rdy_pct = ((c / 500) % 3 == 0) ? 90 : ((c / 500) % 3 == 1) ? 40 : 10;
            if (r < 22) valid_in = '1;
            else if (r < 25) valid_in = N'($urandom_range(1, (1 << N) - 2));
            else valid_in = '0;
            for (int i = 0; i < N; i++) C_in[i*MW +: MW] = MW'({$urandom(), $urandom()});
            rif.out_ready = ($urandom_range(0, 99) < rdy_pct);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        valid_in = '0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
